// File: rtl/id_branch_ctrl_pkg.sv
// Shared MIPS decode constants for the ID-stage branch controller.
package id_branch_ctrl_pkg;
    localparam logic [5:0] OP_BEQ    = 6'b000100;
    localparam logic [5:0] OP_BNE    = 6'b000101;
    localparam logic [5:0] OP_J      = 6'b000010;
    localparam int         CNT_W_DEF = 16;
endpackage

// File: rtl/id_branch_ctrl_if.sv
// Fetch/decode/register-file bundle seen by the ID branch controller.
import id_branch_ctrl_pkg::*;

interface id_branch_ctrl_if #(parameter int CNT_W = CNT_W_DEF);
    logic [31:0]      instr;
    logic [31:0]      pcplus4_addr;
    logic             stall;
    logic [31:0]      rd1_data;
    logic [31:0]      rd2_data;
    logic             PCSrc;
    logic [31:0]      PCBranch;
    logic [31:0]      id_instr;
    logic [31:0]      id_pcplus4;
    logic             id_valid;
    logic [4:0]       rs_addr;
    logic [4:0]       rt_addr;
    logic [CNT_W-1:0] taken_cnt;

    // Fetch / hazard / register-file side
    modport master (
        output instr, pcplus4_addr, stall, rd1_data, rd2_data,
        input  PCSrc, PCBranch, id_instr, id_pcplus4, id_valid,
               rs_addr, rt_addr, taken_cnt
    );

    // Decode-stage controller side
    modport slave (
        input  instr, pcplus4_addr, stall, rd1_data, rd2_data,
        output PCSrc, PCBranch, id_instr, id_pcplus4, id_valid,
               rs_addr, rt_addr, taken_cnt
    );
endinterface

// File: rtl/id_branch_ctrl_branch_target.sv
// Combinational branch/jump resolution: taken decision and redirect target.
import id_branch_ctrl_pkg::*;

module branch_target (
    input  logic [31:0] i_instr,
    input  logic [31:0] i_pcplus4,
    input  logic        i_valid,
    input  logic        i_stall,
    input  logic [31:0] i_rd1,
    input  logic [31:0] i_rd2,
    output logic        o_pcsrc,
    output logic [31:0] o_pcbranch
);
    logic [5:0]  w_op;
    logic [31:0] w_br_tgt;
    logic [31:0] w_j_tgt;
    logic        w_taken;
    logic        w_is_j;

    assign w_op     = i_instr[31:26];
    assign w_br_tgt = i_pcplus4 + {{14{i_instr[15]}}, i_instr[15:0], 2'b00};
    assign w_j_tgt  = {i_pcplus4[31:28], i_instr[25:0], 2'b00};

    // Opcode decode and compare; anything unrecognised never redirects
    always_comb begin
        w_taken = 1'b0;
        w_is_j  = 1'b0;
        case (w_op)
            OP_BEQ:  w_taken = (i_rd1 == i_rd2);
            OP_BNE:  w_taken = (i_rd1 != i_rd2);
            OP_J: begin
                w_taken = 1'b1;
                w_is_j  = 1'b1;
            end
            default: w_taken = 1'b0;
        endcase
    end

    // A bubble or a stalled stage suppresses the redirect; target is 0 when idle
    assign o_pcsrc    = i_valid & ~i_stall & w_taken;
    assign o_pcbranch = o_pcsrc ? (w_is_j ? w_j_tgt : w_br_tgt) : 32'h0;
endmodule

// File: rtl/id_branch_ctrl.sv
// ID-stage branch controller: decode register, redirect, flush and taken counter.
import id_branch_ctrl_pkg::*;

module id_branch_ctrl #(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic            clk,
    input  logic            rst,
    id_branch_ctrl_if.slave bus
);
    logic [31:0]      r_id_instr;
    logic [31:0]      r_id_pcplus4;
    logic             r_id_valid;
    logic [CNT_W-1:0] r_taken_cnt;
    logic             w_pcsrc;
    logic [31:0]      w_pcbranch;

    branch_target u_branch_target (
        .i_instr    (r_id_instr),
        .i_pcplus4  (r_id_pcplus4),
        .i_valid    (r_id_valid),
        .i_stall    (bus.stall),
        .i_rd1      (bus.rd1_data),
        .i_rd2      (bus.rd2_data),
        .o_pcsrc    (w_pcsrc),
        .o_pcbranch (w_pcbranch)
    );

    // Decode register: hold on stall, bubble after a redirect, else load fetch
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_id_instr   <= 32'h0;
            r_id_pcplus4 <= 32'h0;
            r_id_valid   <= 1'b0;
        end else if (!bus.stall) begin
            if (w_pcsrc) begin
                r_id_instr   <= 32'h0;
                r_id_pcplus4 <= 32'h0;
                r_id_valid   <= 1'b0;
            end else begin
                r_id_instr   <= bus.instr;
                r_id_pcplus4 <= bus.pcplus4_addr;
                r_id_valid   <= 1'b1;
            end
        end
    end

    // Saturating count of redirects; w_pcsrc already excludes stalled cycles
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_taken_cnt <= '0;
        else if (w_pcsrc && (r_taken_cnt != {CNT_W{1'b1}}))
            r_taken_cnt <= r_taken_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    assign bus.PCSrc      = w_pcsrc;
    assign bus.PCBranch   = w_pcbranch;
    assign bus.id_instr   = r_id_instr;
    assign bus.id_pcplus4 = r_id_pcplus4;
    assign bus.id_valid   = r_id_valid;
    assign bus.rs_addr    = r_id_instr[25:21];
    assign bus.rt_addr    = r_id_instr[20:16];
    assign bus.taken_cnt  = r_taken_cnt;
endmodule

// File: tb/tb_id_branch_ctrl.sv
// Self-checking bench for id_branch_ctrl: vector table plus stall/reset/saturation sequences.
module tb_id_branch_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b0;

    id_branch_ctrl_if              bus  ();
    id_branch_ctrl_if #(.CNT_W(4)) bus4 ();

    id_branch_ctrl              dut  (.clk(clk), .rst(rst), .bus(bus));
    id_branch_ctrl #(.CNT_W(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

    // Narrow-counter instance shadows the main stimulus
    assign bus4.instr        = bus.instr;
    assign bus4.pcplus4_addr = bus.pcplus4_addr;
    assign bus4.stall        = bus.stall;
    assign bus4.rd1_data     = bus.rd1_data;
    assign bus4.rd2_data     = bus.rd2_data;

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc4;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic        exp_pcsrc;
        logic [31:0] exp_br;
        logic [4:0]  exp_rs;
        logic [4:0]  exp_rt;
    } vec_t;

    localparam int NV = 10;
    vec_t vecs [NV];
    vec_t sb [$];
    vec_t e;

    int checks  = 0;
    int errors  = 0;
    int exp_cnt = 0;
    logic exp_pcsrc = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_cnt4();
        return (exp_cnt > 15) ? 32'd15 : 32'(exp_cnt);
    endfunction

    // Drive a fetched instruction; if decode holds a taken branch the first edge flushes
    task automatic load(input logic [31:0] ins, input logic [31:0] pc4);
        @(negedge clk);
        bus.instr        = ins;
        bus.pcplus4_addr = pc4;
        bus.stall        = 1'b0;
        @(posedge clk);
        if (exp_pcsrc) begin
            exp_cnt++;
            exp_pcsrc = 1'b0;
            #1;
            chk("flush_valid", 32'(bus.id_valid), 32'd0);
            chk("flush_pcsrc", 32'(bus.PCSrc), 32'd0);
            chk("flush_cnt", 32'(bus.taken_cnt), 32'(exp_cnt));
            @(posedge clk);
        end
        #1;
    endtask

    initial begin
        bus.instr        = 32'h0;
        bus.pcplus4_addr = 32'h0;
        bus.stall        = 1'b0;
        bus.rd1_data     = 32'h0;
        bus.rd2_data     = 32'h0;

        //          instr         pc4           rd1    rd2    pcsrc target        rs  rt
        vecs[0] = '{32'h10220003, 32'h00000104, 32'd5, 32'd5, 1'b1, 32'h00000110, 5'd1, 5'd2};
        vecs[1] = '{32'h14220003, 32'h00000200, 32'd7, 32'd7, 1'b0, 32'h00000000, 5'd1, 5'd2};
        vecs[2] = '{32'h14220003, 32'h00000200, 32'd7, 32'd8, 1'b1, 32'h0000020C, 5'd1, 5'd2};
        vecs[3] = '{32'h10220003, 32'h00000200, 32'd1, 32'd2, 1'b0, 32'h00000000, 5'd1, 5'd2};
        vecs[4] = '{32'h08000040, 32'h00400004, 32'd0, 32'd0, 1'b1, 32'h00000100, 5'd0, 5'd0};
        vecs[5] = '{32'h1022FFFF, 32'h00000004, 32'd0, 32'd0, 1'b1, 32'h00000000, 5'd1, 5'd2};
        vecs[6] = '{32'h10220002, 32'hFFFFFFFC, 32'd0, 32'd0, 1'b1, 32'h00000004, 5'd1, 5'd2};
        vecs[7] = '{32'h00221820, 32'h00000040, 32'd3, 32'd3, 1'b0, 32'h00000000, 5'd1, 5'd2};
        vecs[8] = '{32'h0BFFFFFF, 32'hA0000000, 32'd0, 32'd1, 1'b1, 32'hAFFFFFFC, 5'd31, 5'd31};
        vecs[9] = '{32'h0C000040, 32'h00000040, 32'd0, 32'd0, 1'b0, 32'h00000000, 5'd0, 5'd0};

        // Reset state before any clock edge
        #2;
        chk("rst_id_instr", bus.id_instr, 32'h0);
        chk("rst_id_pc4", bus.id_pcplus4, 32'h0);
        chk("rst_valid", 32'(bus.id_valid), 32'd0);
        chk("rst_pcsrc", 32'(bus.PCSrc), 32'd0);
        chk("rst_pcbranch", bus.PCBranch, 32'h0);
        chk("rst_rs", 32'(bus.rs_addr), 32'd0);
        chk("rst_rt", 32'(bus.rt_addr), 32'd0);
        chk("rst_cnt", 32'(bus.taken_cnt), 32'd0);
        chk("rst_cnt4", 32'(bus4.taken_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Table vectors through the scoreboard
        for (int i = 0; i < NV; i++) begin
            sb.push_back(vecs[i]);
            load(vecs[i].instr, vecs[i].pc4);
            bus.rd1_data = vecs[i].rd1;
            bus.rd2_data = vecs[i].rd2;
            #1;
            e = sb.pop_front();
            chk($sformatf("v%0d_valid", i), 32'(bus.id_valid), 32'd1);
            chk($sformatf("v%0d_id_instr", i), bus.id_instr, e.instr);
            chk($sformatf("v%0d_id_pc4", i), bus.id_pcplus4, e.pc4);
            chk($sformatf("v%0d_rs", i), 32'(bus.rs_addr), 32'(e.exp_rs));
            chk($sformatf("v%0d_rt", i), 32'(bus.rt_addr), 32'(e.exp_rt));
            chk($sformatf("v%0d_pcsrc", i), 32'(bus.PCSrc), 32'(e.exp_pcsrc));
            chk($sformatf("v%0d_pcbranch", i), bus.PCBranch, e.exp_br);
            chk($sformatf("v%0d_cnt", i), 32'(bus.taken_cnt), 32'(exp_cnt));
            exp_pcsrc = e.exp_pcsrc;
        end

        // Taken beq held by a 3-cycle stall, then released
        load(32'h10220003, 32'h00000104);
        bus.rd1_data = 32'd5;
        bus.rd2_data = 32'd5;
        #1;
        chk("stl_pre_pcsrc", 32'(bus.PCSrc), 32'd1);
        @(negedge clk);
        bus.stall = 1'b1;
        bus.instr = 32'hDEADBEEF;
        #1;
        chk("stl_pcsrc", 32'(bus.PCSrc), 32'd0);
        chk("stl_pcbranch", bus.PCBranch, 32'h0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("stl%0d_hold", k), bus.id_instr, 32'h10220003);
            chk($sformatf("stl%0d_valid", k), 32'(bus.id_valid), 32'd1);
            chk($sformatf("stl%0d_pcsrc", k), 32'(bus.PCSrc), 32'd0);
            chk($sformatf("stl%0d_cnt", k), 32'(bus.taken_cnt), 32'(exp_cnt));
        end
        @(negedge clk);
        bus.stall = 1'b0;
        #1;
        chk("stl_rel_pcsrc", 32'(bus.PCSrc), 32'd1);
        chk("stl_rel_pcbranch", bus.PCBranch, 32'h00000110);
        @(posedge clk);
        exp_cnt++;
        #1;
        chk("stl_flush_valid", 32'(bus.id_valid), 32'd0);
        chk("stl_flush_instr", bus.id_instr, 32'h0);
        chk("stl_flush_cnt", 32'(bus.taken_cnt), 32'(exp_cnt));

        // Reset asserted between edges while a jump is being taken
        load(32'h08000040, 32'h00400004);
        #1;
        chk("mid_pre_pcsrc", 32'(bus.PCSrc), 32'd1);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        exp_cnt   = 0;
        exp_pcsrc = 1'b0;
        chk("mid_rst_pcsrc", 32'(bus.PCSrc), 32'd0);
        chk("mid_rst_pcbranch", bus.PCBranch, 32'h0);
        chk("mid_rst_valid", 32'(bus.id_valid), 32'd0);
        chk("mid_rst_cnt", 32'(bus.taken_cnt), 32'd0);
        chk("mid_rst_cnt4", 32'(bus4.taken_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        bus.instr        = 32'h00221820;
        bus.pcplus4_addr = 32'h00000044;
        @(posedge clk);
        #1;
        chk("post_rst_valid", 32'(bus.id_valid), 32'd1);
        chk("post_rst_instr", bus.id_instr, 32'h00221820);

        // 17 taken jumps: 4-bit counter must pin at 0xF
        for (int k = 0; k < 17; k++) begin
            load(32'h08000040, 32'h00400004);
            exp_pcsrc = 1'b1;
            if (k == 15 || k == 16)
                chk($sformatf("sat%0d_cnt4", k), 32'(bus4.taken_cnt), exp_cnt4());
        end
        load(32'h0, 32'h0);
        chk("sat_cnt4", 32'(bus4.taken_cnt), 32'h0000000F);
        chk("sat_cnt16", 32'(bus.taken_cnt), 32'd17);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule

// File: doc/id_branch_ctrl.md
ID_BRANCH_CTRL -- requirements
Module: id_branch_ctrl

Interface
REQ-001 Parameter CNT_W, default 16, width of the taken-branch counter.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low (0 = reset).
REQ-004 instr  input  32  fetched instruction from the fetch stage.
REQ-005 pcplus4_addr  input  32  PC+4 of the fetched instruction.
REQ-006 stall  input  1  hazard-unit hold request for the decode stage.
REQ-007 rd1_data  input  32  register-file read data for rs.
REQ-008 rd2_data  input  32  register-file read data for rt.
REQ-009 PCSrc  output  1  branch/jump taken; fetch selects PCBranch.
REQ-010 PCBranch  output  32  redirect target address.
REQ-011 id_instr  output  32  instruction held in the decode stage.
REQ-012 id_pcplus4  output  32  PC+4 held in the decode stage.
REQ-013 id_valid  output  1  decode stage holds a real instruction (not a bubble).
REQ-014 rs_addr  output  5  id_instr[25:21], register-file read address 1.
REQ-015 rt_addr  output  5  id_instr[20:16], register-file read address 2.
REQ-016 taken_cnt  output  CNT_W  count of redirects issued.

Function
REQ-017 Decode register (id_instr, id_pcplus4, id_valid) SHALL load instr, pcplus4_addr, 1 on each edge when stall=0 and PCSrc=0.
REQ-018 When stall=1, the decode register SHALL hold its value and taken_cnt SHALL hold.
REQ-019 When PCSrc=1 and stall=0, the next edge SHALL load a bubble: id_instr=0, id_pcplus4=0, id_valid=0 (one-cycle flush).
REQ-020 Opcode id_instr[31:26]: 000100 beq, 000101 bne, 000010 j; every other opcode is non-redirecting.
REQ-021 Taken condition: beq with rd1_data==rd2_data; bne with rd1_data!=rd2_data; j always.
REQ-022 PCSrc SHALL be combinational: id_valid & ~stall & taken.
REQ-023 Branch target = id_pcplus4 + (sign-extended id_instr[15:0] shifted left 2), modulo 2^32.
REQ-024 Jump target = {id_pcplus4[31:28], id_instr[25:0], 2'b00}.
REQ-025 PCBranch SHALL equal the selected target when PCSrc=1 and 32'h0 otherwise.
REQ-026 Simultaneous stall and taken: stall wins; PCSrc=0, no flush, no count.
REQ-027 taken_cnt SHALL increment by 1 on each edge where PCSrc=1, saturating at all-ones.
REQ-028 Bubble in decode (id_valid=0) SHALL never assert PCSrc, regardless of id_instr.

Reset
REQ-029 On rst=0, immediately and independent of clk: id_instr=0, id_pcplus4=0, id_valid=0, taken_cnt=0; hence PCSrc=0, PCBranch=0, rs_addr=0, rt_addr=0.
REQ-030 Reset asserted mid-branch SHALL cancel the redirect in the same cycle; first edge after rst=1 loads instr normally.

Structure
REQ-031 Opcode constants (OP_BEQ, OP_BNE, OP_J) and CNT_W default SHALL live in the shared MIPS package.
REQ-032 One combinational sub-module, branch_target, SHALL compute both targets and the select.

Verification
REQ-033 beq, id_pcplus4=0x00000104, imm=0x0003, rd1=rd2=5 -> PCSrc=1, PCBranch=0x00000110; next cycle id_valid=0, taken_cnt=1.
REQ-034 bne, rd1=rd2=7 -> PCSrc=0, PCBranch=0; next instruction loads, id_valid=1.
REQ-035 j instr=0x08000040, id_pcplus4=0x00400004 -> PCBranch=0x00000100; imm=0xFFFF with id_pcplus4=0x4 -> PCBranch=0x00000000; id_pcplus4=0xFFFFFFFC, imm=0x0002 -> 0x00000004.
REQ-036 Taken beq with stall=1 for 3 cycles -> PCSrc=0, decode held, taken_cnt unchanged; stall drop -> PCSrc=1 that cycle.
REQ-037 Assert rst=0 between edges while PCSrc=1 -> PCSrc, id_valid, taken_cnt all 0 before next edge.
REQ-038 CNT_W=4, 17 taken jumps -> taken_cnt stays 0xF.
